// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry front end.
// Holds the entry FSM states, the step encodings and small state decoders.
package calc_pkg;

  localparam int OP_W = 8;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    LOAD_A = 3'd1,
    WAIT_B = 3'd2,
    LOAD_B = 3'd3,
    WAIT_Z = 3'd4,
    LOAD_Z = 3'd5
  } seq_state_t;

  localparam logic [1:0] STEP_A = 2'd0;
  localparam logic [1:0] STEP_B = 2'd1;
  localparam logic [1:0] STEP_Z = 2'd2;

  function automatic logic [1:0] state_step(input seq_state_t s);
    case (s)
      WAIT_A, LOAD_A: return STEP_A;
      WAIT_B, LOAD_B: return STEP_B;
      WAIT_Z, LOAD_Z: return STEP_Z;
      default:        return STEP_A;
    endcase
  endfunction

  // Successor WAIT state once a load pulse has completed; Z wraps back to A.
  function automatic seq_state_t next_wait(input seq_state_t s);
    case (s)
      LOAD_A:  return WAIT_B;
      LOAD_B:  return WAIT_Z;
      default: return WAIT_A;
    endcase
  endfunction

  function automatic logic is_load(input seq_state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_Z);
  endfunction

endpackage

// File: rtl/entry_sequencer_if.sv
// Operand-entry bus: raw key/switch inputs and the load strobes toward the datapath.
// master = sequencer side, slave = stimulus/datapath side.
interface entry_sequencer_if;
  import calc_pkg::*;

  logic            key_n;
  logic [OP_W-1:0] sw;
  logic [OP_W-1:0] data;
  logic            loadA;
  logic            loadB;
  logic            loadZ;
  logic [1:0]      step;
  logic            busy;

  modport master (
    input  key_n, sw,
    output data, loadA, loadB, loadZ, step, busy
  );

  modport slave (
    output key_n, sw,
    input  data, loadA, loadB, loadZ, step, busy
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stability-counter debounce and press detector for one key.
// press is a registered one-cycle strobe on a debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          key_s;

  assign key_s = sync[1];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      // Any cycle that agrees with the settled level restarts the stability window.
      if (key_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= key_s;
        cnt   <= '0;
        press <= ~key_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// Operand-entry front end: one debounced press steps A -> B -> Z, each producing a
// single active-low load pulse of PULSE_CYCLES with data held stable across it.
module entry_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  entry_sequencer_if.master  bus
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_END = PW'(PULSE_CYCLES);

  logic [1:0][OP_W-1:0] sw_sync;
  logic [OP_W-1:0]      sw_s;
  logic                 key_level;
  logic                 press;
  logic                 evt;

  seq_state_t           state;
  logic [PW-1:0]        pcnt;
  logic [OP_W-1:0]      data_q;
  logic [2:0]           load_n;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .CLK   (CLK),
    .CLR   (CLR),
    .key_n (bus.key_n),
    .level (key_level),
    .press (press)
  );

  assign sw_s = sw_sync[1];
  // press already implies a low settled level; the qualifier keeps the two in lockstep.
  assign evt  = press & ~key_level;

  function automatic logic [2:0] load_mask(input seq_state_t s);
    case (s)
      LOAD_A:  return 3'b110;
      LOAD_B:  return 3'b101;
      LOAD_Z:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sw_sync <= '0;
      state   <= WAIT_A;
      pcnt    <= '0;
      data_q  <= '0;
      load_n  <= 3'b111;
    end else begin
      sw_sync <= {sw_sync[0], bus.sw};
      case (state)
        WAIT_A: if (evt) begin
          state  <= LOAD_A;
          pcnt   <= '0;
          data_q <= sw_s;
        end
        WAIT_B: if (evt) begin
          state  <= LOAD_B;
          pcnt   <= '0;
          data_q <= sw_s;
        end
        // Z captures the adder result downstream, so the operand stays put.
        WAIT_Z: if (evt) begin
          state <= LOAD_Z;
          pcnt  <= '0;
        end
        LOAD_A, LOAD_B, LOAD_Z: begin
          if (pcnt == PULSE_END) begin
            load_n <= 3'b111;
            state  <= next_wait(state);
          end else begin
            load_n <= load_mask(state);
            pcnt   <= pcnt + 1'b1;
          end
        end
        default: begin
          state  <= WAIT_A;
          load_n <= 3'b111;
        end
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.loadA = load_n[0];
  assign bus.loadB = load_n[1];
  assign bus.loadZ = load_n[2];
  assign bus.step  = state_step(state);
  assign bus.busy  = is_load(state);

endmodule
